fp_align_prep: RTL and testbench

Two-stage pipelined operand-preparation stage of the 32-bit floating-point adder, directly upstream of the mantissa right shifter. It unpacks two IEEE-754 single-precision operands, classifies specials, applies subtraction as a sign flip, and orders the operands by magnitude. Its outputs are the larger operand's exponent, both 24-bit mantissas with the hidden bit, and a saturated 5-bit shift amount that feeds the shifter's `man`/`shamt` inputs. Transfers use valid/ready handshakes on both sides.

---
 rtl/fp_align_prep.sv | 171 +++++++++++++++++
 tb/tb_fp_align_prep.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_prep.sv
// fp_align_prep: two-stage operand prep for the fp32 adder ahead of the
// mantissa right shifter; unpacks, classifies, orders operands by magnitude.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        input handshake for operands a, b and sub
//   out_valid/out_ready      output handshake for the ordered bundle
//   exp_big, man_big,        larger operand's effective exponent and
//   man_small                both 24-bit mantissas (hidden bit included)
//   shamt                    exponent difference, saturated to SHAMT_MAX
//   sign_big, sign_small,    effective signs and their XOR
//   eff_sub
//   is_nan, is_inf, inf_sign special-result flags
module fp_align_prep #(
    parameter int unsigned SHAMT_MAX = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_big,
    output logic [23:0] man_big,
    output logic [23:0] man_small,
    output logic [4:0]  shamt,
    output logic        sign_big,
    output logic        sign_small,
    output logic        eff_sub,
    output logic        is_nan,
    output logic        is_inf,
    output logic        inf_sign
);

    localparam logic [7:0] SAT8 = 8'(SHAMT_MAX);
    localparam logic [4:0] SAT5 = 5'(SHAMT_MAX);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] man;
        fp_class_t   cls;
    } op_t;

    typedef struct packed {
        logic [7:0]  exp_big;
        logic [23:0] man_big;
        logic [23:0] man_small;
        logic [4:0]  shamt;
        logic        sign_big;
        logic        sign_small;
        logic        eff_sub;
        logic        is_nan;
        logic        is_inf;
        logic        inf_sign;
    } res_t;

    // Zero/denormal operands use exponent 1 so the difference lines up
    // with normals at the minimum exponent.
    function automatic op_t unpack_op(input logic [31:0] x,
                                      input logic flip);
        op_t o;
        logic [7:0]  e;
        logic [22:0] f;
        e = x[30:23];
        f = x[22:0];
        o.sign = x[31] ^ flip;
        o.exp  = (e == 8'd0) ? 8'd1 : e;
        o.man  = {e != 8'd0, f};
        o.cls  = CLS_NORMAL;
        unique case (1'b1)
            (e == 8'd0   && f == 23'd0): o.cls = CLS_ZERO;
            (e == 8'd0   && f != 23'd0): o.cls = CLS_DENORM;
            (e == 8'hFF  && f == 23'd0): o.cls = CLS_INF;
            (e == 8'hFF  && f != 23'd0): o.cls = CLS_NAN;
            (e != 8'd0   && e != 8'hFF): o.cls = CLS_NORMAL;
            default:                     o.cls = CLS_NORMAL;
        endcase
        return o;
    endfunction

    logic v1;
    logic v2;
    logic adv1;
    logic adv2;
    op_t  s1_a;
    op_t  s1_b;
    res_t s2;
    res_t s2_n;

    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1 && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            s1_a <= '0;
            s1_b <= '0;
        end else if (adv1) begin
            v1   <= in_valid;
            s1_a <= unpack_op(a, 1'b0);
            s1_b <= unpack_op(b, sub);
        end
    end

    logic       a_big;
    logic       a_inf;
    logic       b_inf;
    logic [7:0] exp_small;
    logic [7:0] diff;

    always_comb begin
        s2_n  = '0;
        // Tie goes to a, so equal magnitudes keep a's sign as sign_big.
        a_big = {s1_a.exp, s1_a.man} >= {s1_b.exp, s1_b.man};
        a_inf = s1_a.cls == CLS_INF;
        b_inf = s1_b.cls == CLS_INF;

        s2_n.exp_big    = a_big ? s1_a.exp  : s1_b.exp;
        exp_small       = a_big ? s1_b.exp  : s1_a.exp;
        s2_n.man_big    = a_big ? s1_a.man  : s1_b.man;
        s2_n.man_small  = a_big ? s1_b.man  : s1_a.man;
        s2_n.sign_big   = a_big ? s1_a.sign : s1_b.sign;
        s2_n.sign_small = a_big ? s1_b.sign : s1_a.sign;
        s2_n.eff_sub    = s2_n.sign_big ^ s2_n.sign_small;

        diff       = s2_n.exp_big - exp_small;
        s2_n.shamt = (diff > SAT8) ? SAT5 : diff[4:0];

        s2_n.is_nan = (s1_a.cls == CLS_NAN) || (s1_b.cls == CLS_NAN) ||
                      (a_inf && b_inf && (s1_a.sign != s1_b.sign));
        s2_n.is_inf = !s2_n.is_nan && (a_inf || b_inf);
        s2_n.inf_sign = s2_n.is_inf &&
                        (a_inf ? s1_a.sign : s1_b.sign);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            s2 <= s2_n;
        end
    end

    assign out_valid  = v2;
    assign exp_big    = s2.exp_big;
    assign man_big    = s2.man_big;
    assign man_small  = s2.man_small;
    assign shamt      = s2.shamt;
    assign sign_big   = s2.sign_big;
    assign sign_small = s2.sign_small;
    assign eff_sub    = s2.eff_sub;
    assign is_nan     = s2.is_nan;
    assign is_inf     = s2.is_inf;
    assign inf_sign   = s2.inf_sign;

endmodule

// File: tb/tb_fp_align_prep.sv
// tb_fp_align_prep: directed vector table plus backpressure and
// mid-stream reset sequences for fp_align_prep.
module tb_fp_align_prep;

    typedef struct packed {
        logic [7:0]  exp_big;
        logic [23:0] man_big;
        logic [23:0] man_small;
        logic [4:0]  shamt;
        logic        sign_big;
        logic        sign_small;
        logic        eff_sub;
        logic        is_nan;
        logic        is_inf;
        logic        inf_sign;
    } res_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  exp_big;
    logic [23:0] man_big;
    logic [23:0] man_small;
    logic [4:0]  shamt;
    logic        sign_big;
    logic        sign_small;
    logic        eff_sub;
    logic        is_nan;
    logic        is_inf;
    logic        inf_sign;

    int n_checks = 0;
    int n_fail = 0;
    vec_t vecs[$];

    fp_align_prep #(.SHAMT_MAX(31)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_big(exp_big), .man_big(man_big), .man_small(man_small),
        .shamt(shamt), .sign_big(sign_big), .sign_small(sign_small),
        .eff_sub(eff_sub), .is_nan(is_nan), .is_inf(is_inf),
        .inf_sign(inf_sign)
    );

    always #5 clk = ~clk;

    function automatic res_t get_res();
        return {exp_big, man_big, man_small, shamt, sign_big,
                sign_small, eff_sub, is_nan, is_inf, inf_sign};
    endfunction

    // flags = {sign_big, sign_small, eff_sub, is_nan, is_inf, inf_sign}
    task automatic add(input string nm, input logic [31:0] va,
                       input logic [31:0] vb, input logic vs,
                       input logic [7:0] eb, input logic [23:0] mb,
                       input logic [23:0] ms, input logic [4:0] sh,
                       input logic [5:0] fl);
        vec_t v;
        v.name = nm;
        v.a = va;
        v.b = vb;
        v.sub = vs;
        v.exp = {eb, mb, ms, sh, fl};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [66:0] got,
                       input logic [66:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic drive(input int i);
        a = vecs[i].a;
        b = vecs[i].b;
        sub = vecs[i].sub;
    endtask

    initial begin
        add("add_1_2",      32'h3F800000, 32'h40000000, 1'b0,
            8'h80, 24'h800000, 24'h800000, 5'd1,  6'b000000);
        add("sub_equal",    32'h40400000, 32'h40400000, 1'b1,
            8'h80, 24'hC00000, 24'hC00000, 5'd0,  6'b011000);
        add("sat_denorm",   32'h00000001, 32'h7F000000, 1'b0,
            8'hFE, 24'h800000, 24'h000001, 5'd31, 6'b000000);
        add("inf_m_inf",    32'h7F800000, 32'hFF800000, 1'b0,
            8'hFF, 24'h800000, 24'h800000, 5'd0,  6'b011100);
        add("inf_p_one",    32'h7F800000, 32'h3F800000, 1'b0,
            8'hFF, 24'h800000, 24'h800000, 5'd31, 6'b000010);
        add("qnan",         32'h7FC00000, 32'h3F800000, 1'b0,
            8'hFF, 24'hC00000, 24'h800000, 5'd31, 6'b000100);
        add("sub_neg_b",    32'h40A00000, 32'hC0000000, 1'b1,
            8'h81, 24'hA00000, 24'h800000, 5'd1,  6'b000000);
        add("sub_b_big",    32'h3F800000, 32'h41200000, 1'b1,
            8'h82, 24'hA00000, 24'h800000, 5'd3,  6'b101000);
        add("zeros",        32'h00000000, 32'h80000000, 1'b0,
            8'h01, 24'h000000, 24'h000000, 5'd0,  6'b011000);
        add("ninf_s_pinf",  32'hFF800000, 32'h7F800000, 1'b1,
            8'hFF, 24'h800000, 24'h800000, 5'd0,  6'b110011);
        add("one_s_inf",    32'h3F800000, 32'h7F800000, 1'b1,
            8'hFF, 24'h800000, 24'h800000, 5'd31, 6'b101011);
        add("diff30",       32'h4E800000, 32'h3F800000, 1'b0,
            8'h9D, 24'h800000, 24'h800000, 5'd30, 6'b000000);
        add("diff31",       32'h4F000000, 32'h3F800000, 1'b0,
            8'h9E, 24'h800000, 24'h800000, 5'd31, 6'b000000);
        add("diff32",       32'h4F800000, 32'h3F800000, 1'b0,
            8'h9F, 24'h800000, 24'h800000, 5'd31, 6'b000000);
        add("man_order",    32'h3F800001, 32'h3FC00000, 1'b0,
            8'h7F, 24'hC00000, 24'h800001, 5'd0,  6'b000000);
        add("denorm_norm",  32'h00400000, 32'h00800000, 1'b0,
            8'h01, 24'h800000, 24'h400000, 5'd0,  6'b000000);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 67'(out_valid), 67'd0);
        chk("rst_in_ready", 67'(in_ready), 67'd0);
        chk("rst_outputs", 67'(get_res()), 67'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 67'(in_ready), 67'd1);
        chk("post_rst_out_valid", 67'(out_valid), 67'd0);

        // Table: one pair at a time, result 2 edges after accept
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(i);
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_valid"}, 67'(out_valid), 67'd1);
            chk(vecs[i].name, 67'(get_res()), 67'(vecs[i].exp));
        end
        repeat (2) @(posedge clk);

        // Backpressure: 5 pairs, out_ready low for first 4 cycles
        begin
            int idx = 0;
            int nout = 0;
            int cyc = 0;
            bit stalled = 0;
            while (nout < 5 && cyc < 40) begin
                @(negedge clk);
                out_ready = (cyc >= 4);
                in_valid = (idx < 5);
                if (idx < 5) drive(idx);
                #1;
                if (!in_ready && !stalled) begin
                    stalled = 1;
                    chk("bp_accepts_before_stall", 67'(idx), 67'd2);
                end
                if (out_valid && !out_ready)
                    chk("bp_frozen", 67'(get_res()), 67'(vecs[0].exp));
                if (out_valid && out_ready) begin
                    chk($sformatf("bp_out%0d", nout), 67'(get_res()),
                        67'(vecs[nout].exp));
                    nout++;
                end
                if (in_valid && in_ready) idx++;
                cyc++;
            end
            chk("bp_saw_stall", 67'(stalled), 67'd1);
            chk("bp_all_out", 67'(nout), 67'd5);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_no_extra", 67'(out_valid), 67'd0);
        end

        // Mid-stream reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(6);
        @(negedge clk);
        drive(7);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_full_valid", 67'(out_valid), 67'd1);
        chk("mr_full_in_ready", 67'(in_ready), 67'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_valid", 67'(out_valid), 67'd0);
        chk("mr_async_outputs", 67'(get_res()), 67'd0);
        chk("mr_async_in_ready", 67'(in_ready), 67'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        drive(1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mr_lat1_valid", 67'(out_valid), 67'd0);
        @(posedge clk);
        #1;
        chk("mr_lat2_valid", 67'(out_valid), 67'd1);
        chk("mr_result", 67'(get_res()), 67'(vecs[1].exp));
        @(posedge clk);
        #1;
        chk("mr_single", 67'(out_valid), 67'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
